// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer
// Command queue and transaction sequencer sitting directly in front of
// i2c_master. Host commands are buffered in a DEPTH-entry FIFO, issued to the
// master as one-cycle write_en/read_en strobes, tracked through the master's
// busy signal, retried on a non-zero status and timed out if the master hangs.
// Each command returns exactly one response.
//
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   cmd_valid/cmd_ready   host command handshake (push when both high)
//   cmd_rw, cmd_chip_addr, cmd_reg_addr, cmd_data
//                         command fields (1 = read, 0 = write)
//   flush                 drop every queued command (in-flight one still completes)
//   level, idle           FIFO occupancy, and FIFO empty with sequencer at rest
//   rsp_*                 one-cycle response pulse with rw, read data, error, retries
//   m_*                   address/data/strobes to the master, busy/status/data back
module i2c_cmd_sequencer #(
  parameter int DEPTH      = 8,
  parameter int MAX_RETRY  = 2,
  parameter int START_TO   = 16,
  parameter int DONE_TO    = 65535,
  parameter int GAP_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_rw,
  input  logic [6:0]               cmd_chip_addr,
  input  logic [7:0]               cmd_reg_addr,
  input  logic [15:0]              cmd_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle,
  output logic                     rsp_valid,
  output logic                     rsp_rw,
  output logic [15:0]              rsp_data,
  output logic                     rsp_err,
  output logic [1:0]               rsp_retries,
  output logic [6:0]               m_chip_addr,
  output logic [7:0]               m_reg_addr,
  output logic [15:0]              m_data_in,
  output logic                     m_write_en,
  output logic                     m_read_en,
  input  logic                     m_busy,
  input  logic [3:0]               m_status,
  input  logic [15:0]              m_data_out
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int TO_MAX = (START_TO > DONE_TO) ? START_TO : DONE_TO;
  localparam int CW     = $clog2(TO_MAX + 1);
  localparam int GW     = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  // FIFO entry layout: {rw, chip_addr, reg_addr, data}
  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [GW-1:0] gap_r;
  logic [1:0]    retry_r;
  logic          retrying_r;
  logic          cur_rw_r;

  logic [6:0]    m_chip_addr_r;
  logic [7:0]    m_reg_addr_r;
  logic [15:0]   m_data_in_r;
  logic          m_write_en_r;
  logic          m_read_en_r;
  logic          rsp_valid_r;
  logic          rsp_rw_r;
  logic [15:0]   rsp_data_r;
  logic          rsp_err_r;
  logic [1:0]    rsp_retries_r;

  logic          cmd_ready_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   head_s;

  // Ready comes from the registered level, so a same-cycle pop never frees a slot early.
  assign cmd_ready_s = (level_r != LW'(DEPTH));
  // A push coinciding with flush is dropped; no pop is taken while flushing.
  assign push_s      = cmd_valid & cmd_ready_s & ~flush;
  assign pop_s       = (state_r == S_IDLE) & (level_r != LW'(0)) & ~flush;
  assign head_s      = mem_r[rd_ptr_r];

  assign cmd_ready   = cmd_ready_s;
  assign level       = level_r;
  assign idle        = (level_r == LW'(0)) & (state_r == S_IDLE);
  assign m_chip_addr = m_chip_addr_r;
  assign m_reg_addr  = m_reg_addr_r;
  assign m_data_in   = m_data_in_r;
  assign m_write_en  = m_write_en_r;
  assign m_read_en   = m_read_en_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rw      = rsp_rw_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_retries = rsp_retries_r;

  // Command storage: written at the write pointer on every accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cmd_rw, cmd_chip_addr, cmd_reg_addr, cmd_data};
    end
  end

  // FIFO pointers and occupancy; flush empties by snapping the read pointer to the write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else if (flush) begin
      rd_ptr_r <= wr_ptr_r;
      level_r  <= LW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_r + LW'(push_s) - LW'(pop_s);
    end
  end

  // Sequencer FSM: strobes and responses are registered on entry to S_ISSUE / S_RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      cnt_r         <= CW'(0);
      gap_r         <= GW'(0);
      retry_r       <= 2'd0;
      retrying_r    <= 1'b0;
      cur_rw_r      <= 1'b0;
      m_chip_addr_r <= 7'd0;
      m_reg_addr_r  <= 8'd0;
      m_data_in_r   <= 16'd0;
      m_write_en_r  <= 1'b0;
      m_read_en_r   <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rw_r      <= 1'b0;
      rsp_data_r    <= 16'd0;
      rsp_err_r     <= 1'b0;
      rsp_retries_r <= 2'd0;
    end else begin
      // Strobes and the response pulse are single-cycle by default.
      m_write_en_r <= 1'b0;
      m_read_en_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            {cur_rw_r, m_chip_addr_r, m_reg_addr_r, m_data_in_r} <= head_s;
            retry_r      <= 2'd0;
            m_write_en_r <= ~head_s[31];
            m_read_en_r  <= head_s[31];
            state_r      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_r   <= CW'(0);
          state_r <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (m_busy) begin
            cnt_r   <= CW'(0);
            state_r <= S_WAIT_DONE;
          end else if (cnt_r == CW'(START_TO - 1)) begin
            // Master never started: report as error, never retried.
            rsp_valid_r   <= 1'b1;
            rsp_rw_r      <= cur_rw_r;
            rsp_err_r     <= 1'b1;
            rsp_data_r    <= 16'd0;
            rsp_retries_r <= retry_r;
            state_r       <= S_RESP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!m_busy) begin
            if ((m_status != 4'd0) && (retry_r < 2'(MAX_RETRY))) begin
              retry_r    <= retry_r + 2'd1;
              retrying_r <= 1'b1;
              gap_r      <= GW'(0);
              state_r    <= S_GAP;
            end else begin
              rsp_valid_r   <= 1'b1;
              rsp_rw_r      <= cur_rw_r;
              rsp_err_r     <= (m_status != 4'd0);
              rsp_data_r    <= (cur_rw_r && (m_status == 4'd0)) ? m_data_out : 16'd0;
              rsp_retries_r <= retry_r;
              state_r       <= S_RESP;
            end
          end else if (cnt_r == CW'(DONE_TO - 1)) begin
            // Master stuck busy: report as error, never retried.
            rsp_valid_r   <= 1'b1;
            rsp_rw_r      <= cur_rw_r;
            rsp_err_r     <= 1'b1;
            rsp_data_r    <= 16'd0;
            rsp_retries_r <= retry_r;
            state_r       <= S_RESP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        S_RESP: begin
          retrying_r <= 1'b0;
          gap_r      <= GW'(0);
          state_r    <= S_GAP;
        end
        S_GAP: begin
          if (gap_r == GW'(GAP_CYCLES - 1)) begin
            gap_r <= GW'(0);
            if (retrying_r) begin
              // Re-issue with the held address/data.
              retrying_r   <= 1'b0;
              m_write_en_r <= ~cur_rw_r;
              m_read_en_r  <= cur_rw_r;
              state_r      <= S_ISSUE;
            end else begin
              state_r <= S_IDLE;
            end
          end else begin
            gap_r <= gap_r + GW'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
